// File: rtl/cic_interpolator.sv
// CIC interpolator: N comb stages at the input rate, zero-stuffing by R, N integrators at the
// output rate; unity DC gain is restored by a final arithmetic shift and output saturation.
module cic_interpolator #(
  parameter  int DATA_W = 16,
  parameter  int R      = 8,
  parameter  int N      = 3,
  localparam int LOG2R  = $clog2(R),
  localparam int W_INT  = DATA_W + N * LOG2R
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int SHIFT = (N - 1) * LOG2R;

  // Clip a wide two's-complement value into the DATA_W output range.
  function automatic logic [DATA_W-1:0] sat_out(input logic signed [W_INT-1:0] v);
    logic [W_INT-DATA_W:0] top;
    top = v[W_INT-1:DATA_W-1];
    if ((&top) || !(|top)) begin
      return v[DATA_W-1:0];
    end else if (v[W_INT-1]) begin
      return {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end
  endfunction

  logic [LOG2R-1:0]        phase_r;
  logic signed [W_INT-1:0] dly_r       [N];
  logic signed [W_INT-1:0] integ_r     [N];
  logic [DATA_W-1:0]       out_data_r;
  logic                    out_valid_r;

  logic signed [W_INT-1:0] comb_in_s   [N];
  logic signed [W_INT-1:0] integ_nxt_s [N];
  logic signed [W_INT-1:0] x_s;
  logic signed [W_INT-1:0] scaled_s;
  logic                    phase0_s;
  logic                    free_s;
  logic                    adv_s;

  // Handshake: the filter advances when the output slot is free and, in phase 0, a sample is offered.
  always_comb begin
    phase0_s = (phase_r == {LOG2R{1'b0}});
    free_s   = !out_valid_r || out_ready;
    adv_s    = free_s && (!phase0_s || in_valid);
    in_ready = reset && free_s && phase0_s;
  end

  // Comb chain on the incoming sample; comb_in_s[k] is the value stage k stores as its delay.
  always_comb begin : comb_chain
    logic signed [W_INT-1:0] c;
    c = {{(W_INT-DATA_W){in_data[DATA_W-1]}}, in_data};
    for (int k = 0; k < N; k++) begin
      comb_in_s[k] = c;
      c = c - dly_r[k];
    end
    if (phase0_s) begin
      x_s = c;
    end else begin
      x_s = {W_INT{1'b0}};
    end
  end

  // Integrators step in parallel from old values; wrap-around is intentional and cancels out.
  always_comb begin
    integ_nxt_s[0] = integ_r[0] + x_s;
    for (int k = 1; k < N; k++) begin
      integ_nxt_s[k] = integ_r[k] + integ_r[k-1];
    end
    scaled_s = integ_nxt_s[N-1] >>> SHIFT;
  end

  // Filter state and registered output; everything holds unless the pipeline advances.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_r <= {LOG2R{1'b0}};
      for (int k = 0; k < N; k++) begin
        dly_r[k]   <= {W_INT{1'b0}};
        integ_r[k] <= {W_INT{1'b0}};
      end
      out_data_r  <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
    end else if (adv_s) begin
      phase_r <= phase_r + LOG2R'(1'b1);
      if (phase0_s) begin
        for (int k = 0; k < N; k++) begin
          dly_r[k] <= comb_in_s[k];
        end
      end
      for (int k = 0; k < N; k++) begin
        integ_r[k] <= integ_nxt_s[k];
      end
      out_data_r  <= sat_out(scaled_s);
      out_valid_r <= 1'b1;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;

endmodule

// File: doc/cic_interpolator.md
Name: cic_interpolator

Overview:
- CIC interpolation filter: the transmit-side counterpart of the CIC decimation filter in the sigma-delta chain.
- Accepts Q1.15 samples at the low rate through a valid/ready handshake, upsamples by R through N comb and N integrator stages, and streams Q1.15 samples at up to clock rate to the downstream sigma-delta modulator.
- Output is scaled to unity DC gain.

Parameters:
- DATA_W, 16, sample width in Q1.15 format, used for both input and output.
- R, 8, interpolation ratio. Must be a power of two, 2..64. LOG2R is derived from it.
- N, 3, number of stages, 1..5. Differential delay M is fixed at 1.
- W_INT, DATA_W+N*LOG2R, derived, not overridable. Internal comb/integrator width.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-low; all state cleared while low.
- in_data, input, DATA_W, signed Q1.15 low-rate sample.
- in_valid, input, 1, in_data holds a sample.
- in_ready, output, 1, block accepts in_data this cycle.
- out_data, output, DATA_W, signed Q1.15 high-rate sample.
- out_valid, output, 1, out_data is valid.
- out_ready, output-side input, 1, downstream consumes out_data this cycle.

Behaviour:
- Reset (reset low, async):
  - phase counter 0, all comb delay registers 0, all integrators 0.
  - out_data 0, out_valid 0.
  - in_ready forced 0 while reset is low.
- Phase counter counts 0..R-1 and wraps to 0. A new input sample is consumed only in phase 0.
- free = !out_valid || out_ready.
- in_ready = free && (phase == 0). Combinational. Never depends on in_valid.
- adv = free && (phase != 0 || in_valid). The filter steps only on adv. Without adv, every register holds.
- On adv at phase 0 (input accepted):
  - Comb chain is combinational, W_INT-bit wrap-around: c0 = sext(in_data); ck = c(k-1) - d_k.
  - On the same edge, d_k <= c(k-1).
  - Upsampler value x = cN.
- On adv at phase != 0: x = 0 (zero stuffing).
- On every adv:
  - Integrators update in parallel, modulo 2^W_INT: I1 <= I1 + x; Ik <= Ik + I(k-1) using old values.
  - phase <= phase + 1 mod R.
  - out_data <= sat16(I_N_next >>> (N-1)*LOG2R), with an arithmetic shift and floor.
  - out_valid <= 1.
- If !adv and out_ready: out_valid <= 0. out_data holds its last value.
- Saturation: clip to [-32768, 32767]. Never triggers for legal input (every polyphase gain is R^(N-1)). It is kept as a safeguard.
- Latency: an impulse accepted on advance k first appears nonzero in out_data after advance k+N-1. Impulse response = coefficients of (1+z^-1+...+z^-(R-1))^N / R^(N-1).
- Underrun: in_valid low at phase 0 freezes the pipeline, and out_valid drops once the current beat is consumed. There are no zero-inserted artifacts; the resumed stream is identical to an uninterrupted one.
- Backpressure: out_valid high with out_ready low holds out_data, out_valid, phase and all state. in_ready stays low. No sample is lost or duplicated.
- Simultaneous events:
  - out_ready and in_valid in the same cycle at phase 0 give acceptance and a new output on the same edge.
  - reset low overrides everything.
- Reset mid-operation discards all state, including any partially emitted R-burst. After release, phase 0 and in_ready = 1 on the first cycle.
- Integrator wrap-around is intentional and must not be saturated internally. Only the final stage output is clipped.

Test Plan:
- Impulse, with R=8, N=3, out_ready=1 and in_valid=1 throughout: one sample 0x4000 then zeros.
  - Required output sequence is 256 x (1,3,6,10,15,21,28,36,42,46,48,48,46,42,36,28,21,15,10,6,3,1); sum = 16384·8.
  - First nonzero appears at the 3rd advance.
- Step: constant in_data = 0x4000 → after 24 advances, out_data = 16384 every cycle and in_ready is high 1 cycle in 8.
- Negative full-scale step: constant in_data = 0x8000 → settles to -32768 with no wrap, overflow sign flip or glitch.
- Backpressure: drive a sine (100 samples/period, amplitude 0x4000) and hold out_ready low for 5 random cycles in each burst.
  - out_data and out_valid are held during each stall.
  - The captured stream must equal the unstalled reference bit-exactly.
- Underrun: deassert in_valid for 20 cycles at phase 0 → out_valid low after the current beat, and the resumed stream equals the reference.
- Reset mid-burst: pull reset low at phase 4 → out_data = 0 and out_valid = 0 immediately (async); after release, in_ready = 1 and the impulse test repeats exactly.
